// File: rtl/jtframe_hscaler_pkg.sv
// Shared definitions for the jtframe horizontal scaler.
// JTFRAME_HSCALER_INTERP_EN selects the 2-tap interpolating datapath,
// which adds one pixel of pipeline latency.
package jtframe_hscaler_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } state_t;

`ifdef JTFRAME_HSCALER_INTERP_EN
    localparam int PIPE_DEPTH = 3;
`else
    localparam int PIPE_DEPTH = 2;
`endif

    // Line RAM address width for a given line length
    function automatic int calc_vw(input int width);
        if (width <= 256) begin
            return 8;
        end else if (width <= 512) begin
            return 9;
        end else begin
            return 10;
        end
    endfunction

endpackage

// File: rtl/jtframe_dual_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
module jtframe_dual_ram #(
    parameter int DW = 8,
    parameter int AW = 10
)(
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] q
);

    logic [DW-1:0] mem [0:(2**AW)-1];

    // Storage write and registered read
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            q <= mem[raddr];
        end
    end

endmodule

// File: rtl/jtframe_hscaler_blend.sv
// Per-channel 2-tap linear blender with quarter-pixel weights.
// Only compiled when JTFRAME_HSCALER_INTERP_EN is defined.
`ifdef JTFRAME_HSCALER_INTERP_EN
module jtframe_hscaler_blend #(
    parameter int COLORW = 4
)(
    input  logic [COLORW-1:0] p0,
    input  logic [COLORW-1:0] p1,
    input  logic [1:0]        f,
    output logic [COLORW-1:0] y
);

    logic [2:0]        w0_s;
    logic [2:0]        w1_s;
    logic [COLORW+1:0] acc_s;

    // y = (p0*(4-f) + p1*f) / 4; the sum never exceeds 4*max(p)
    always_comb begin
        w0_s  = 3'd4 - {1'b0, f};
        w1_s  = {1'b0, f};
        acc_s = (COLORW+2)'(p0) * (COLORW+2)'(w0_s)
              + (COLORW+2)'(p1) * (COLORW+2)'(w1_s);
        y     = COLORW'(acc_s >> 2);
    end

endmodule
`endif

// File: rtl/jtframe_hscaler.sv
// Horizontal video scaler: each line is stored in a double-buffered line RAM
// and replayed on the following line through a fractional DDA.
// Optional macro: JTFRAME_HSCALER_INTERP_EN (2-tap interpolation, +1 latency).
module jtframe_hscaler
    import jtframe_hscaler_pkg::*;
#(
    parameter int CHANNELS    = 3,
    parameter int COLORW      = 4,
    parameter int VIDEO_WIDTH = 384,
    parameter int FRACW       = 8,
    parameter int OFSW        = 6
)(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pxl_cen,
    input  logic                       enable,
    input  logic [FRACW+1:0]           step,
    input  logic [OFSW-1:0]            offset,
    input  logic [CHANNELS*COLORW-1:0] rgb_in,
    input  logic                       HS_in,
    input  logic                       VS_in,
    input  logic                       HB_in,
    input  logic                       VB_in,
    output logic [CHANNELS*COLORW-1:0] rgb_out,
    output logic                       HS_out,
    output logic                       VS_out,
    output logic                       HB_out,
    output logic                       VB_out
);

    localparam int DW    = CHANNELS*COLORW;
    localparam int STEPW = FRACW+2;
    localparam int VW    = calc_vw(VIDEO_WIDTH);
    localparam int PW    = VW+FRACW+2;
    localparam int SW    = DW+6;
    localparam int NSTG  = PIPE_DEPTH-1;
    localparam logic [VW-1:0] LAST   = VW'(VIDEO_WIDTH-1);
    localparam logic [VW+1:0] LAST_X = (VW+2)'(VIDEO_WIDTH-1);

    // ---------------- write side ----------------
    logic          hsl_q, hsl_d, hs_edge_s;
    logic          line_q, line_d;
    logic [VW-1:0] wrcnt_q, wrcnt_d;

    // Line toggle and saturating write counter
    always_comb begin
        hs_edge_s = HS_in & ~hsl_q;
        hsl_d     = HS_in;
        if (hs_edge_s) begin
            line_d  = ~line_q;
            wrcnt_d = '0;
        end else if (wrcnt_q != LAST) begin
            line_d  = line_q;
            wrcnt_d = wrcnt_q + VW'(1);
        end else begin
            line_d  = line_q;
            wrcnt_d = wrcnt_q;
        end
    end

    // Write-side registers
    always_ff @(posedge clk) begin
        if (rst) begin
            hsl_q   <= 1'b0;
            line_q  <= 1'b0;
            wrcnt_q <= '0;
        end else if (pxl_cen) begin
            hsl_q   <= hsl_d;
            line_q  <= line_d;
            wrcnt_q <= wrcnt_d;
        end
    end

    // ---------------- read side (DDA) ----------------
    state_t          state_q, state_d;
    logic [PW-1:0]   phase_q, phase_d;
    logic [STEPW-1:0] step_l_q, step_l_d;
    logic            en_l_q, en_l_d;
    logic [VW+1:0]   int_s;
    logic            neg_s, past_s, valid_s;
    logic [PW-1:0]   step_ext_s, ofs_ext_s;

    // Phase accumulator, window detection and next-state logic
    always_comb begin
        int_s      = phase_q[PW-1:FRACW];
        neg_s      = int_s[VW+1];
        past_s     = !neg_s && (int_s > LAST_X);
        valid_s    = (state_q == RUN) && !neg_s && !past_s;
        step_ext_s = {{(PW-STEPW){1'b0}}, step_l_q};
        ofs_ext_s  = {{(PW-OFSW-FRACW){offset[OFSW-1]}}, offset, {FRACW{1'b0}}};
        state_d    = state_q;
        phase_d    = phase_q;
        step_l_d   = step_l_q;
        en_l_d     = en_l_q;
        if (hs_edge_s) begin
            state_d  = RUN;
            phase_d  = ofs_ext_s;
            step_l_d = step;
            en_l_d   = enable;
        end else begin
            case (state_q)
                RUN: begin
                    if (past_s) begin
                        state_d = OVER;
                    end else begin
                        phase_d = phase_q + step_ext_s;
                    end
                end
                IDLE, OVER: state_d = state_q;
                default:    state_d = IDLE;
            endcase
        end
    end

    // Read state machine with per-line latched controls
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            phase_q  <= '0;
            step_l_q <= '0;
            en_l_q   <= 1'b0;
        end else if (pxl_cen) begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            step_l_q <= step_l_d;
            en_l_q   <= en_l_d;
        end
    end

    // ---------------- line storage and pixel datapath ----------------
    logic [DW-1:0] pix_s;

`ifdef JTFRAME_HSCALER_INTERP_EN
    logic [VW-2:0] half_s, ea_s;
    logic          odd_s, end_s;
    logic          odd_q, odd_d, end_q, end_d;
    logic [1:0]    frac_q, frac_d;
    logic [DW-1:0] qe_s, qo_s, p0_s, p1_s, blend_s, blend_q, blend_d;

    // Even/odd bank addressing so p0 and p1 are fetched together
    always_comb begin
        half_s  = int_s[VW-1:1];
        odd_s   = int_s[0];
        end_s   = (int_s[VW-1:0] == LAST);
        ea_s    = odd_s ? (half_s + (VW-1)'(1)) : half_s;
        odd_d   = odd_s;
        end_d   = end_s;
        frac_d  = phase_q[FRACW-1 -: 2];
        p0_s    = odd_q ? qo_s : qe_s;
        p1_s    = end_q ? p0_s : (odd_q ? qe_s : qo_s);
        blend_d = blend_s;
    end

    jtframe_dual_ram #(.DW(DW), .AW(VW)) u_ram_even (
        .clk   (clk),
        .we    (pxl_cen & ~wrcnt_q[0]),
        .waddr ({line_q, wrcnt_q[VW-1:1]}),
        .wdata (rgb_in),
        .re    (pxl_cen),
        .raddr ({~line_q, ea_s}),
        .q     (qe_s)
    );

    jtframe_dual_ram #(.DW(DW), .AW(VW)) u_ram_odd (
        .clk   (clk),
        .we    (pxl_cen & wrcnt_q[0]),
        .waddr ({line_q, wrcnt_q[VW-1:1]}),
        .wdata (rgb_in),
        .re    (pxl_cen),
        .raddr ({~line_q, half_s}),
        .q     (qo_s)
    );

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_blend
        jtframe_hscaler_blend #(.COLORW(COLORW)) u_blend (
            .p0 (p0_s[ch*COLORW +: COLORW]),
            .p1 (p1_s[ch*COLORW +: COLORW]),
            .f  (frac_q),
            .y  (blend_s[ch*COLORW +: COLORW])
        );
    end

    // Tap selection side data and blended pixel register
    always_ff @(posedge clk) begin
        if (rst) begin
            odd_q   <= 1'b0;
            end_q   <= 1'b0;
            frac_q  <= 2'd0;
            blend_q <= '0;
        end else if (pxl_cen) begin
            odd_q   <= odd_d;
            end_q   <= end_d;
            frac_q  <= frac_d;
            blend_q <= blend_d;
        end
    end

    assign pix_s = blend_q;
`else
    logic [DW-1:0] ram_q_s;

    jtframe_dual_ram #(.DW(DW), .AW(VW+1)) u_ram (
        .clk   (clk),
        .we    (pxl_cen),
        .waddr ({line_q, wrcnt_q}),
        .wdata (rgb_in),
        .re    (pxl_cen),
        .raddr ({~line_q, int_s[VW-1:0]}),
        .q     (ram_q_s)
    );

    assign pix_s = ram_q_s;
`endif

    // ---------------- sideband delay line ----------------
    logic [SW-1:0] side_s;
    logic [SW-1:0] side_q [NSTG];
    logic [SW-1:0] side_d [NSTG];

    // Syncs, raw pixel, valid and mode travel alongside the RAM pipeline
    always_comb begin
        side_s    = {rgb_in, HS_in, VS_in, HB_in, VB_in, valid_s, en_l_q};
        side_d[0] = side_s;
        for (int i = 1; i < NSTG; i++) begin
            side_d[i] = side_q[i-1];
        end
    end

    // Sideband pipeline registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NSTG; i++) begin
                side_q[i] <= '0;
            end
        end else if (pxl_cen) begin
            for (int i = 0; i < NSTG; i++) begin
                side_q[i] <= side_d[i];
            end
        end
    end

    // ---------------- output register ----------------
    logic [DW-1:0] o_rgb_s, rgb_out_q, rgb_out_d;
    logic          o_hs_s, o_vs_s, o_hb_s, o_vb_s, o_val_s, o_en_s;
    logic          hs_out_q, hs_out_d, vs_out_q, vs_out_d;
    logic          hb_out_q, hb_out_d, vb_out_q, vb_out_d;

    // Choose scaled or pass-through pixel; blank outside the displayed window
    always_comb begin
        {o_rgb_s, o_hs_s, o_vs_s, o_hb_s, o_vb_s, o_val_s, o_en_s} = side_q[NSTG-1];
        hs_out_d = o_hs_s;
        vs_out_d = o_vs_s;
        vb_out_d = o_vb_s;
        if (o_en_s) begin
            rgb_out_d = o_val_s ? pix_s : '0;
            hb_out_d  = o_hb_s | ~o_val_s;
        end else begin
            rgb_out_d = o_rgb_s;
            hb_out_d  = o_hb_s;
        end
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_out_q <= '0;
            hs_out_q  <= 1'b0;
            vs_out_q  <= 1'b0;
            hb_out_q  <= 1'b0;
            vb_out_q  <= 1'b0;
        end else if (pxl_cen) begin
            rgb_out_q <= rgb_out_d;
            hs_out_q  <= hs_out_d;
            vs_out_q  <= vs_out_d;
            hb_out_q  <= hb_out_d;
            vb_out_q  <= vb_out_d;
        end
    end

    assign rgb_out = rgb_out_q;
    assign HS_out  = hs_out_q;
    assign VS_out  = vs_out_q;
    assign HB_out  = hb_out_q;
    assign VB_out  = vb_out_q;

endmodule

// File: tb/tb_jtframe_hscaler.sv
// Scoreboard bench for jtframe_hscaler in its default (nearest-pixel) build.
module tb_jtframe_hscaler;

    localparam int LEN = 400;   // clocks-enables per line, edge at j=0
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pxl_cen = 1'b0;
    logic        enable = 1'b0;
    logic [9:0]  step = 10'd0;
    logic [5:0]  offset = 6'd0;
    logic [11:0] rgb_in = 12'd0;
    logic        HS_in = 1'b0, VS_in = 1'b0, HB_in = 1'b0, VB_in = 1'b0;
    logic [11:0] rgb_out;
    logic        HS_out, VS_out, HB_out, VB_out;

    typedef struct {
        bit          chk_d;
        logic [11:0] rgb;
        logic        hs, vs, hb, vb;
        int          line;
        int          j;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   prev_seed = 0;
    int   line_no = 0;

    jtframe_hscaler #(
        .CHANNELS(3), .COLORW(4), .VIDEO_WIDTH(384), .FRACW(8), .OFSW(6)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .pxl_cen (pxl_cen),
        .enable  (enable),
        .step    (step),
        .offset  (offset),
        .rgb_in  (rgb_in),
        .HS_in   (HS_in),
        .VS_in   (VS_in),
        .HB_in   (HB_in),
        .VB_in   (VB_in),
        .rgb_out (rgb_out),
        .HS_out  (HS_out),
        .VS_out  (VS_out),
        .HB_out  (HB_out),
        .VB_out  (VB_out)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One pixel-enable period: cen pulse on one edge, idle on the next
    task automatic tick();
        pxl_cen = 1'b1;
        @(posedge clk);
        #1;
        pxl_cen = 1'b0;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] pix_val(input int seed, input int n);
        return 12'(n + seed*37);
    endfunction

    task automatic check_zero(input string tag);
        check_val({tag, " rgb"}, 32'(rgb_out), 32'd0);
        check_val({tag, " HS"},  32'(HS_out),  32'd0);
        check_val({tag, " VS"},  32'(VS_out),  32'd0);
        check_val({tag, " HB"},  32'(HB_out),  32'd0);
        check_val({tag, " VB"},  32'(VB_out),  32'd0);
    endtask

    // Drive one line; expected output is derived from the previous line's data
    task automatic run_line(input int seed, input bit en, input int stp, input int ofs,
                            input bit chk_d, input int tog_at, input int rst_at);
        bit   dead;
        exp_t e;
        exp_t g;
        int   pos, ip;
        bit   vld;
        dead   = 1'b0;
        enable = en;
        step   = 10'(stp);
        offset = 6'(ofs);
        for (int j = 0; j < LEN; j++) begin
            if (j == tog_at) enable = ~en;
            if (j == rst_at) begin
                rst = 1'b1;
                tick();
                check_zero($sformatf("L%0d rst", line_no));
                rst = 1'b0;
                sb.delete();
                dead = 1'b1;
            end
            HS_in  = (j < 4);
            HB_in  = (j == 0) || (j > 384);
            VS_in  = ((j >= 10) && (j < 14)) ^ (seed % 2 == 1);
            VB_in  = (seed % 3 == 0);
            rgb_in = (j == 0) ? pix_val(prev_seed, 383) : pix_val(seed, (j > 384) ? 383 : j-1);
            e.hs = HS_in; e.vs = VS_in; e.hb = HB_in; e.vb = VB_in;
            e.line = line_no; e.j = j;
            e.chk_d = chk_d && !dead && (j > 0);
            if (en) begin
                pos = ofs*256 + (j-1)*stp;
                ip  = pos >>> 8;
                vld = (ip >= 0) && (ip <= 383);
                e.rgb = vld ? pix_val(prev_seed, ip) : 12'd0;
                e.hb  = HB_in | !vld;
            end else begin
                e.rgb = rgb_in;
                e.hb  = HB_in;
            end
            sb.push_back(e);
            tick();
            if (sb.size() >= LAT) begin
                g = sb.pop_front();
                check_val($sformatf("L%0d j%0d HS", g.line, g.j), 32'(HS_out), 32'(g.hs));
                check_val($sformatf("L%0d j%0d VS", g.line, g.j), 32'(VS_out), 32'(g.vs));
                check_val($sformatf("L%0d j%0d VB", g.line, g.j), 32'(VB_out), 32'(g.vb));
                if (g.chk_d) begin
                    check_val($sformatf("L%0d j%0d rgb", g.line, g.j), 32'(rgb_out), 32'(g.rgb));
                    check_val($sformatf("L%0d j%0d HB", g.line, g.j), 32'(HB_out), 32'(g.hb));
                end
            end
        end
        prev_seed = seed;
        line_no++;
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) tick();
        check_zero("reset");
        rst = 1'b0;
        //        seed en  step    ofs chk tog   rst
        run_line(0,   1, 'h100,  0,  0,  -1,   -1);  // fill RAM
        run_line(1,   1, 'h100,  0,  1,  -1,   -1);  // 1:1
        run_line(2,   1, 'h080,  0,  1,  -1,   -1);  // x2 magnify
        run_line(3,   1, 'h200,  0,  1,  -1,   -1);  // /2 shrink, OVER
        run_line(4,   1, 'h100, -4,  1,  -1,   -1);  // negative offset
        run_line(5,   1, 'h100,  3,  1,  -1,   -1);  // positive offset
        run_line(6,   1, 'h000,  5,  1,  -1,   -1);  // step 0
        run_line(7,   0, 'h100,  0,  1, 200,   -1);  // pass-through, enable toggles mid-line
        run_line(8,   1, 'h0C0,  0,  1, 200,   -1);  // scaled, enable toggles mid-line
        run_line(9,   1, 'h100,  0,  1,  -1,  150);  // reset mid-line
        run_line(10,  1, 'h100,  0,  0,  -1,   -1);  // first edge after reset
        run_line(11,  1, 'h100,  0,  1,  -1,   -1);  // after second edge
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
